// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
// Used by regfile_clear_seq and regfile_mp.
package regfile_pkg;

  // Sequencer states: CLEAR walks the array writing zeros, RUN is normal operation
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Index of the hardwired-zero register
  localparam int ZERO_IDX = 0;

  // Address width for a register count; never narrower than one bit
  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset clear sequencer for regfile_mp.
// After reset it issues one zero-write per cycle to every entry in turn,
// holding busy high, then switches permanently to RUN until the next reset.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Next state: advance the counter through every entry, leave CLEAR after the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      if (cnt_q == LAST_IDX) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  // State and counter registers; reset restarts the clear from entry 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file for the ID stage.
// One writeback port, NRD registered read ports with write-first forwarding,
// optional hardwired-zero register 0. The array itself has no reset; the
// clear sequencer zeroes it entry by entry after every reset (busy = 1).
// Optional feature macro: REGFILE_SCOREBOARD_EN adds per-register pending
// bits (claim_en/claim_addr inputs, rd_pending output).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [NRD-1:0]      rd_pending,
`endif
  output logic                busy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          ext_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_q [NREGS];

  logic [AW-1:0]       port_addr [NRD];
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;

  regfile_clear_seq #(
    .NREGS (NREGS)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // An external write lands unless it targets the hardwired-zero register
  assign ext_we = wen && !(ZERO_REG && (waddr == ZERO_ADDR));

  // Unpack the read addresses so each port can be handled by index
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      port_addr[i] = rd_addr[i*AW +: AW];
    end
  end

  // Array write path: the clear sequencer owns the port while busy, writeback otherwise
  always_comb begin
    mem_we    = ext_we;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  // Storage array: deliberately unreset, the clear sequence initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read capture: zero while clearing, hold on stall, else zero-reg/forward/array
  always_comb begin
    rd_data_d = rd_data_q;
    if (busy) begin
      rd_data_d = '0;
    end else if (en) begin
      for (int i = 0; i < NRD; i++) begin
        if (ZERO_REG && (port_addr[i] == ZERO_ADDR)) begin
          rd_data_d[i*XLEN +: XLEN] = '0;
        end else if (ext_we && (waddr == port_addr[i])) begin
          rd_data_d[i*XLEN +: XLEN] = wdata;
        end else begin
          rd_data_d[i*XLEN +: XLEN] = mem_q[port_addr[i]];
        end
      end
    end
  end

  // Registered read data, forced to zero by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] pend_q, pend_d;
  logic [NRD-1:0]   rd_pend_q, rd_pend_d;

  // Pending bits: a write clears, a claim sets (claim wins), register 0 never pending
  always_comb begin
    pend_d = pend_q;
    if (busy) begin
      pend_d = '0;
    end else begin
      if (wen) begin
        pend_d[waddr] = 1'b0;
      end
      if (claim_en) begin
        pend_d[claim_addr] = 1'b1;
      end
      if (ZERO_REG) begin
        pend_d[ZERO_IDX] = 1'b0;
      end
    end
  end

  // Pending read-out follows rd_data timing and sees this cycle's updates
  always_comb begin
    rd_pend_d = rd_pend_q;
    if (busy) begin
      rd_pend_d = '0;
    end else if (en) begin
      for (int i = 0; i < NRD; i++) begin
        rd_pend_d[i] = pend_d[port_addr[i]];
      end
    end
  end

  // Pending state and registered pending outputs, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= '0;
      rd_pend_q <= '0;
    end else begin
      pend_q    <= pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rd_pending = rd_pend_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp (default parameters).
// A behavioural model tracks the register contents, clear duration and read
// results; a compare process checks every cycle, plus directed literal checks.
module tb_regfile_mp;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int NRD      = 2;
  localparam bit ZERO_REG = 1'b1;
  localparam int AW       = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wen = 1'b0;
  logic [AW-1:0]       waddr = '0;
  logic [XLEN-1:0]     wdata = '0;
  logic                busy;
`ifdef REGFILE_SCOREBOARD_EN
  logic                claim_en = 1'b0;
  logic [AW-1:0]       claim_addr = '0;
  logic [NRD-1:0]      rd_pending;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
`ifdef REGFILE_SCOREBOARD_EN
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_pending (rd_pending),
`endif
    .busy       (busy)
  );

  // Behavioural model state
  logic [XLEN-1:0]  m_mem [NREGS];
  logic [XLEN-1:0]  m_rd  [NRD];
  bit   [NREGS-1:0] m_pend;
  bit   [NREGS-1:0] m_pnext;
  bit   [NRD-1:0]   m_rpend;
  int               m_clr_left = 0;
  int               m_a;
  bit               model_valid = 1'b0;

  task automatic check_output(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: reset starts an NREGS-cycle clear, then reads/writes follow the register-file rules
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clr_left = NREGS;
      for (int i = 0; i < NRD; i++) m_rd[i] = '0;
      m_rpend     = '0;
      m_pend      = '0;
      model_valid = 1'b1;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
      for (int i = 0; i < NRD; i++) m_rd[i] = '0;
      m_rpend = '0;
      m_pend  = '0;
      if (m_clr_left == 0) begin
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
      end
    end else begin
      m_pnext = m_pend;
`ifdef REGFILE_SCOREBOARD_EN
      if (wen) m_pnext[waddr] = 1'b0;
      if (claim_en) m_pnext[claim_addr] = 1'b1;
`endif
      if (ZERO_REG) m_pnext[0] = 1'b0;
      if (en) begin
        for (int i = 0; i < NRD; i++) begin
          m_a = int'(rd_addr[i*AW +: AW]);
          if (ZERO_REG && m_a == 0) m_rd[i] = '0;
          else if (wen && int'(waddr) == m_a) m_rd[i] = wdata;
          else m_rd[i] = m_mem[m_a];
          m_rpend[i] = m_pnext[m_a];
        end
      end
      if (wen && !(ZERO_REG && waddr == '0)) m_mem[waddr] = wdata;
      m_pend = m_pnext;
    end
  end

  // Compare process: every falling edge, DUT outputs against the model
  always @(negedge clk) begin
    if (model_valid) begin
      check_output("busy", XLEN'(busy), XLEN'(m_clr_left > 0));
      for (int i = 0; i < NRD; i++) begin
        check_output($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN], m_rd[i]);
`ifdef REGFILE_SCOREBOARD_EN
        check_output($sformatf("rd_pending%0d", i), XLEN'(rd_pending[i]), XLEN'(m_rpend[i]));
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then wait until the result is visible
  task automatic apply_stimulus(input logic w, input logic [AW-1:0] wa,
                                input logic [XLEN-1:0] wd, input logic e,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    wen     = w;
    waddr   = wa;
    wdata   = wd;
    en      = e;
    rd_addr = {a1, a0};
    step();
  endtask

  // Count consecutive sampled cycles with busy high, bounded
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      n++;
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    $display("[TB] start");
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    count_busy(n);
    check_output("busy_len", XLEN'(n), 32'd32);

    // Every register reads zero after the clear
    for (int r = 0; r < NREGS; r += 2) begin
      apply_stimulus(1'b0, '0, '0, 1'b1, AW'(r), AW'(r + 1));
      check_output("clr_p0", rd_data[31:0], 32'h0);
      check_output("clr_p1", rd_data[63:32], 32'h0);
    end

    // Plain write then read
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd5, '0);
    check_output("x5_read", rd_data[31:0], 32'hDEADBEEF);
    check_output("model_x5", m_rd[0], 32'hDEADBEEF);

    // Same-cycle forwarding to both ports
    apply_stimulus(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7);
    check_output("fwd_p0", rd_data[31:0], 32'h12345678);
    check_output("fwd_p1", rd_data[63:32], 32'h12345678);
    check_output("model_fwd", m_rd[1], 32'h12345678);

    // Register 0 ignores writes
    apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    check_output("x0_fwd", rd_data[31:0], 32'h0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
    check_output("x0_p0", rd_data[31:0], 32'h0);
    check_output("x0_p1", rd_data[63:32], 32'h0);

    // Stall holds rd_data while the write still lands
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd5, 5'd7);
    check_output("pre_stall_p0", rd_data[31:0], 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd3, 5'd3);
      check_output("stall_p0", rd_data[31:0], 32'hDEADBEEF);
      check_output("stall_p1", rd_data[63:32], 32'h12345678);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd3, 5'd3);
    check_output("x3_after_stall", rd_data[31:0], 32'hA5A5A5A5);
    check_output("model_x3", m_rd[0], 32'hA5A5A5A5);

`ifdef REGFILE_SCOREBOARD_EN
    claim_en   = 1'b1;
    claim_addr = 5'd4;
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd4, 5'd4);
    claim_en = 1'b0;
    check_output("claim_x4", XLEN'(rd_pending[0]), 32'd1);
    apply_stimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd4, 5'd4);
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd4, 5'd4);
    check_output("write_clears_x4", XLEN'(rd_pending[0]), 32'd0);
    claim_en   = 1'b1;
    claim_addr = 5'd4;
    apply_stimulus(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4);
    claim_en = 1'b0;
    check_output("claim_wins_x4", XLEN'(rd_pending[0]), 32'd1);
`endif

    // Reset mid-clear restarts a full clear; writes during clear are dropped
    rst = 1'b0;
    step();
    rst = 1'b1;
    wen   = 1'b1;
    waddr = 5'd9;
    wdata = 32'h1;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    count_busy(n);
    check_output("busy_len_restart", XLEN'(n), 32'd32);
    apply_stimulus(1'b0, '0, '0, 1'b1, 5'd9, 5'd9);
    check_output("x9_dropped", rd_data[31:0], 32'h0);
    check_output("model_x9", m_rd[1], 32'h0);

    // Randomized traffic, biased towards a few addresses to hit forwarding
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
`ifdef REGFILE_SCOREBOARD_EN
      claim_en   = ($urandom_range(0, 3) == 0);
      claim_addr = AW'($urandom_range(0, 7));
`endif
      apply_stimulus(($urandom_range(0, 1) == 1),
                     AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1)),
                     XLEN'($urandom),
                     ($urandom_range(0, 3) != 0),
                     AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1)),
                     AW'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
